// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider (WIDTH bits) with start/ready/done handshake and divide-by-zero flag.
// Define DIV_SIGNED_EN to add the sgn port for two's-complement division.
//
// state | meaning
// IDLE  | ready, waiting for start
// CALC  | one restoring step per cycle, WIDTH steps
// DONE  | one-cycle done pulse, results valid
module divisor_secuencial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div0
`ifdef DIV_SIGNED_EN
  ,
  input  logic             sgn
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, b_q;
  logic             neg_q_q, neg_r_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             step_ok, last_step, trial_unused;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix;

`ifdef DIV_SIGNED_EN
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // Magnitudes are divided; signs are re-applied when results are registered
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  assign rem_sh       = {rem_q, quo_q[WIDTH-1]};
  assign trial        = {1'b0, rem_sh} - {2'b00, b_q};
  assign step_ok      = ~trial[WIDTH+1];
  assign trial_unused = trial[WIDTH];
  assign rem_nx       = step_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx       = {quo_q[WIDTH-2:0], step_ok};
  assign last_step    = (cnt_q == CW'(WIDTH - 1));

  assign q_fix = neg_q_q ? (~quo_nx + 1'b1) : quo_nx;
  assign r_fix = neg_r_q ? (~rem_nx + 1'b1) : rem_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = (b == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q       <= '0;
      r       <= '0;
      div0    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            b_q     <= b_mag;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            // Zero divisor skips CALC, so its results are registered here
            if (b == '0) begin
              q    <= '1;
              r    <= a;
              div0 <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            q    <= q_fix;
            r    <= r_fix;
            div0 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: 8- and 16-bit instances, directed and random divisions
// against an arithmetic reference model. Signed cases run when DIV_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_divisor_secuencial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start8, ready8, busy8, done8, div08;
   logic [7:0]  a8, b8, q8, r8;
   logic        start16, ready16, busy16, done16, div016;
   logic [15:0] a16, b16, q16, r16;
`ifdef DIV_SIGNED_EN
   logic        sgn8, sgn16;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   bit sel16  = 1'b0;

   divisor_secuencial #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .ready(ready8), .busy(busy8), .done(done8), .q(q8), .r(r8), .div0(div08)
`ifdef DIV_SIGNED_EN
      , .sgn(sgn8)
`endif
   );

   divisor_secuencial #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
      .ready(ready16), .busy(busy16), .done(done16), .q(q16), .r(r16), .div0(div016)
`ifdef DIV_SIGNED_EN
      , .sgn(sgn16)
`endif
   );

   task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic        f_rdy();  return sel16 ? ready16 : ready8; endfunction
   function automatic logic        f_bsy();  return sel16 ? busy16  : busy8;  endfunction
   function automatic logic        f_dn();   return sel16 ? done16  : done8;  endfunction
   function automatic logic        f_dz();   return sel16 ? div016  : div08;  endfunction
   function automatic logic [31:0] f_q();    return sel16 ? 32'(q16) : 32'(q8); endfunction
   function automatic logic [31:0] f_r();    return sel16 ? 32'(r16) : 32'(r8); endfunction

   // Reference: plain integer division; SV signed division truncates toward zero
   function automatic void ref_div(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input bit sg, output logic [31:0] qe, output logic [31:0] re,
                                   output bit de);
      longint mask, ua, ub, sa, sb;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(av) & mask;
      ub   = longint'(bv) & mask;
      de   = (ub == 0);
      if (de) begin
         qe = 32'(mask);
         re = 32'(ua);
      end else if (sg) begin
         sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
         sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
         qe = 32'((sa / sb) & mask);
         re = 32'((sa % sb) & mask);
      end else begin
         qe = 32'(ua / ub);
         re = 32'(ua % ub);
      end
   endfunction

   task automatic set_in(input bit s, input logic [31:0] av, input logic [31:0] bv);
      if (sel16) begin
         start16 = s; a16 = av[15:0]; b16 = bv[15:0];
      end else begin
         start8 = s; a8 = av[7:0]; b8 = bv[7:0];
      end
   endtask

   task automatic run_div(input string name, input int w, input logic [31:0] av,
                          input logic [31:0] bv, input bit sg, input bit poke);
      logic [31:0] qe, re;
      bit          de, seen;
      int          k, busy_n, lat;
      sel16 = (w == 16);
      ref_div(w, av, bv, sg, qe, re, de);
      k = 0;
      while (!f_rdy() && k < 60) begin
         @(negedge clk);
         k++;
      end
      n_chk++; if (f_rdy() !== 1'b1) fail($sformatf("%s/ready", name), f_rdy(), 1'b1);
      set_in(1'b1, av, bv);
`ifdef DIV_SIGNED_EN
      if (sel16) sgn16 = sg; else sgn8 = sg;
`endif
      @(negedge clk);
      set_in(1'b0, $urandom, $urandom);
`ifdef DIV_SIGNED_EN
      if (sel16) sgn16 = ~sg; else sgn8 = ~sg;
`endif
      k = 1; busy_n = 0; seen = 1'b0; lat = 0;
      while (k <= 2 * w + 8 && !seen) begin
         if (f_dn()) begin
            seen = 1'b1;
            lat  = k;
         end else begin
            if (f_bsy()) busy_n++;
            if (poke && k == 3) set_in(1'b1, 50, 5);
            if (poke && k == 4) set_in(1'b0, 50, 5);
            @(negedge clk);
            k++;
         end
      end
      n_chk++; if (seen !== 1'b1) fail($sformatf("%s/done_seen", name), seen, 1'b1);
      n_chk++; if (lat !== (de ? 1 : w + 1)) fail($sformatf("%s/latency", name), lat, (de ? 1 : w + 1));
      n_chk++; if (busy_n !== (de ? 0 : w)) fail($sformatf("%s/busy_cycles", name), busy_n, (de ? 0 : w));
      n_chk++; if (f_q() !== qe) fail($sformatf("%s/q", name), f_q(), qe);
      n_chk++; if (f_r() !== re) fail($sformatf("%s/r", name), f_r(), re);
      n_chk++; if (f_dz() !== de) fail($sformatf("%s/div0", name), f_dz(), de);
      n_chk++; if (f_rdy() !== 1'b0) fail($sformatf("%s/ready_in_done", name), f_rdy(), 1'b0);
      if (poke) set_in(1'b1, 50, 5);
      @(negedge clk);
      if (poke) set_in(1'b0, 0, 0);
      n_chk++; if (f_dn() !== 1'b0) fail($sformatf("%s/done_pulse", name), f_dn(), 1'b0);
      n_chk++; if (f_q() !== qe) fail($sformatf("%s/q_hold", name), f_q(), qe);
      if (poke) begin
         @(negedge clk);
         n_chk++; if (f_rdy() !== 1'b1) fail($sformatf("%s/no_retrigger", name), f_rdy(), 1'b1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    k, dn_n;
      logic [31:0] ra, rb;
      rst = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; a16 = '0; b16 = '0;
`ifdef DIV_SIGNED_EN
      sgn8 = 1'b0; sgn16 = 1'b0;
`endif
      repeat (2) @(negedge clk);
      n_chk++; if (ready8 !== 1'b1) fail("reset/ready", ready8, 1'b1);
      n_chk++; if (busy8 !== 1'b0) fail("reset/busy", busy8, 1'b0);
      n_chk++; if (done8 !== 1'b0) fail("reset/done", done8, 1'b0);
      n_chk++; if (q8 !== 8'h00) fail("reset/q", q8, 8'h00);
      n_chk++; if (r8 !== 8'h00) fail("reset/r", r8, 8'h00);
      n_chk++; if (div08 !== 1'b0) fail("reset/div0", div08, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      run_div("t1_69_7", 8, 32'h45, 32'h07, 1'b0, 1'b0);
      run_div("t2_div0", 8, 32'h45, 32'h00, 1'b0, 1'b0);
      run_div("t2_200_10", 8, 200, 10, 1'b0, 1'b0);
      run_div("t3_255_1", 8, 255, 1, 1'b0, 1'b0);
      run_div("t3_5_200", 8, 5, 200, 1'b0, 1'b0);
      run_div("t3_0_3", 8, 0, 3, 1'b0, 1'b0);
      run_div("t4_ignore", 8, 100, 9, 1'b0, 1'b1);

      // Abort a division with reset; outputs clear asynchronously
      sel16 = 1'b0;
      set_in(1'b1, 69, 7);
      @(negedge clk);
      set_in(1'b0, 0, 0);
      repeat (3) @(negedge clk);
      n_chk++; if (busy8 !== 1'b1) fail("t5/busy_before_rst", busy8, 1'b1);
      #2 rst = 1'b0;
      #1;
      n_chk++; if (q8 !== 8'h00) fail("t5/rst_q", q8, 8'h00);
      n_chk++; if (r8 !== 8'h00) fail("t5/rst_r", r8, 8'h00);
      n_chk++; if (div08 !== 1'b0) fail("t5/rst_div0", div08, 1'b0);
      n_chk++; if (done8 !== 1'b0) fail("t5/rst_done", done8, 1'b0);
      n_chk++; if (busy8 !== 1'b0) fail("t5/rst_busy", busy8, 1'b0);
      n_chk++; if (ready8 !== 1'b1) fail("t5/rst_ready", ready8, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      dn_n = 0;
      for (k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done8) dn_n++;
      end
      n_chk++; if (dn_n !== 0) fail("t5/no_done_after_abort", dn_n, 0);
      run_div("t5_60000_7", 16, 60000, 7, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom_range(0, 255);
         rb = (i % 5 == 0) ? 32'd0 : $urandom_range(1, 255);
         run_div($sformatf("rnd8_%0d", i), 8, ra, rb, 1'b0, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         ra = $urandom_range(0, 65535);
         rb = (i == 3) ? 32'd0 : $urandom_range(1, 65535 >> (i * 2));
         run_div($sformatf("rnd16_%0d", i), 16, ra, rb, 1'b0, 1'b0);
      end

`ifdef DIV_SIGNED_EN
      run_div("t6_m69_7", 8, 32'hBB, 32'h07, 1'b1, 1'b0);
      run_div("t6_69_m7", 8, 32'h45, 32'hF9, 1'b1, 1'b0);
      run_div("t6_ovf", 8, 32'h80, 32'hFF, 1'b1, 1'b0);
      run_div("t6_uns", 8, 32'hBB, 32'h07, 1'b0, 1'b0);
      run_div("t6_div0", 8, 32'hBB, 32'h00, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         ra = $urandom_range(0, 255);
         rb = $urandom_range(1, 255);
         run_div($sformatf("rnds8_%0d", i), 8, ra, rb, 1'b1, 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         ra = $urandom_range(0, 65535);
         rb = $urandom_range(1, 65535);
         run_div($sformatf("rnds16_%0d", i), 16, ra, rb, 1'b1, 1'b0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
